// File: rtl/fetch_decode_queue_pkg.sv
// Shared processor constants for the fetch/decode queue: opcode field,
// HALT encoding, bubble instruction and the queued entry layout.
package fetch_decode_queue_pkg;

    localparam logic [4:0]  OPC_HALT  = 5'b00000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam int          OPC_MSB   = 15;
    localparam int          OPC_LSB   = 11;
    localparam int          ENTRY_W   = 33;

    typedef struct packed {
        logic        err;
        logic [15:0] pc_next;
        logic [15:0] instr;
    } fdq_entry_t;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB] == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch-side and decode-side handshake bundle of the fetch/decode queue.
// master = fetch/decode environment, slave = the queue itself.
interface fetch_decode_queue_if;
    import fetch_decode_queue_pkg::*;

    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_pc_next;
    logic [15:0] if_instr;
    logic        if_err;

    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_pc_next;
    logic [15:0] id_instr;
    logic        id_err;

    modport master (
        output if_valid, if_pc_next, if_instr, if_err, id_ready,
        input  if_ready, id_valid, id_pc_next, id_instr, id_err
    );

    modport slave (
        input  if_valid, if_pc_next, if_instr, if_err, id_ready,
        output if_ready, id_valid, id_pc_next, id_instr, id_err
    );

endinterface

// File: rtl/fetch_decode_queue_storage.sv
// Entry storage for the fetch/decode queue: one synchronous write port and
// a combinational read port so the head entry is visible without a bubble.
module fdq_storage
    import fetch_decode_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  fdq_entry_t       wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output fdq_entry_t       rd_data
);

    // Contents are deliberately not reset; the control logic never exposes
    // an entry that was not written since the last reset or flush.
    fdq_entry_t mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/fetch_decode_queue.sv
// In-order queue between fetch and decode with flush and HALT lock.
// Optional FDQ_STALL_COUNT_EN adds a saturating fetch-stall counter output.
module fetch_decode_queue #(
    parameter int          DEPTH     = 2,
    parameter int          PTR_W     = 1,
    parameter logic [15:0] NOP_INSTR = fetch_decode_queue_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    fetch_decode_queue_if.slave   q,
    output logic                  halted
`ifdef FDQ_STALL_COUNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);
    import fetch_decode_queue_pkg::*;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]   count_reg, count_next;
    logic             halt_lock_reg, halt_lock_next;

    logic             push;
    logic             pop;
    logic             not_empty;
    fdq_entry_t       wr_entry;
    fdq_entry_t       rd_entry;

    // Ready depends on registered state only, keeping id_ready off this path.
    assign q.if_ready = (count_reg != FULL_CNT) & ~halt_lock_reg;
    assign not_empty  = (count_reg != '0);

    assign push = q.if_valid & q.if_ready & ~flush;
    assign pop  = not_empty & q.id_ready & ~flush;

    assign wr_entry.err     = q.if_err;
    assign wr_entry.pc_next = q.if_pc_next;
    assign wr_entry.instr   = q.if_instr;

    fdq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_entry)
    );

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        halt_lock_next = halt_lock_reg;

        if (flush) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            halt_lock_next = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
                if (is_halt(q.if_instr)) begin
                    halt_lock_next = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + (PTR_W+1)'(1);
                2'b01:   count_next = count_reg - (PTR_W+1)'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            halt_lock_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            halt_lock_reg <= halt_lock_next;
        end
    end

    // An empty queue presents a bubble rather than stale storage contents.
    assign q.id_valid   = not_empty;
    assign q.id_instr   = not_empty ? rd_entry.instr   : NOP_INSTR;
    assign q.id_pc_next = not_empty ? rd_entry.pc_next : 16'h0000;
    assign q.id_err     = not_empty ? rd_entry.err     : 1'b0;
    assign halted       = halt_lock_reg;

`ifdef FDQ_STALL_COUNT_EN
    logic [15:0] stall_cnt_reg, stall_cnt_next;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (q.if_valid && !q.if_ready && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
        end
    end

    // Survives flush so software sees stalls accumulated across redirects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= 16'h0000;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue (DEPTH=2).
module tb_fetch_decode_queue;

    logic clk;
    logic rst;
    logic flush;
    logic halted;
`ifdef FDQ_STALL_COUNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_vec;
    int n_err;
    int exp_stall;

    fetch_decode_queue_if bus ();

    fetch_decode_queue #(
        .DEPTH     (2),
        .PTR_W     (1),
        .NOP_INSTR (16'h0800)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .q      (bus),
        .halted (halted)
`ifdef FDQ_STALL_COUNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                         input logic e, input logic rdy, input logic fl);
        bus.if_valid   = v;
        bus.if_pc_next = pc;
        bus.if_instr   = ins;
        bus.if_err     = e;
        bus.id_ready   = rdy;
        flush          = fl;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid got %b exp 0", bus.id_valid); end
        n_vec++; if (bus.id_instr !== 16'h0800) begin n_err++; $display("FAIL reset_id_instr got %h exp 0800", bus.id_instr); end
        n_vec++; if (bus.id_pc_next !== 16'h0000) begin n_err++; $display("FAIL reset_id_pc got %h exp 0000", bus.id_pc_next); end
        n_vec++; if (bus.id_err !== 1'b0) begin n_err++; $display("FAIL reset_id_err got %b exp 0", bus.id_err); end
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b exp 0", halted); end
        n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL reset_if_ready got %b exp 1", bus.if_ready); end
`ifdef FDQ_STALL_COUNT_EN
        n_vec++; if (stall_cnt !== 16'h0000) begin n_err++; $display("FAIL reset_stall_cnt got %h exp 0000", stall_cnt); end
`endif
        rst = 1'b1;
        $display("test_reset: outputs checked, reset released");
    endtask

    task automatic test_flow_through();
        @(negedge clk);
        drive(1'b1, 16'h0002, 16'h4123, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_vec++; if (bus.id_valid !== 1'b1) begin n_err++; $display("FAIL flow_valid got %b exp 1", bus.id_valid); end
        n_vec++; if (bus.id_instr !== 16'h4123) begin n_err++; $display("FAIL flow_instr got %h exp 4123", bus.id_instr); end
        n_vec++; if (bus.id_pc_next !== 16'h0002) begin n_err++; $display("FAIL flow_pc got %h exp 0002", bus.id_pc_next); end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_vec++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL flow_drain_valid got %b exp 0", bus.id_valid); end
        n_vec++; if (bus.id_instr !== 16'h0800) begin n_err++; $display("FAIL flow_drain_instr got %h exp 0800", bus.id_instr); end
        $display("test_flow_through: pushed 4123 pc 0002, popped");
    endtask

    task automatic test_stall_fill();
        drive(1'b1, 16'h0102, 16'h1111, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready1 got %b exp 1", bus.if_ready); end
        drive(1'b1, 16'h0104, 16'h2222, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++; if (bus.if_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready got %b exp 0", bus.if_ready); end
        n_vec++; if (bus.id_instr !== 16'h1111) begin n_err++; $display("FAIL fill_head got %h exp 1111", bus.id_instr); end
        drive(1'b1, 16'h0106, 16'h3333, 1'b0, 1'b0, 1'b0);
        exp_stall++;
        @(negedge clk);
        n_vec++; if (bus.if_ready !== 1'b0) begin n_err++; $display("FAIL fill_hold_ready got %b exp 0", bus.if_ready); end
        n_vec++; if (bus.id_instr !== 16'h1111) begin n_err++; $display("FAIL fill_hold_head got %h exp 1111", bus.id_instr); end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_vec++; if (bus.id_instr !== 16'h2222) begin n_err++; $display("FAIL fill_second got %h exp 2222", bus.id_instr); end
        n_vec++; if (bus.id_pc_next !== 16'h0104) begin n_err++; $display("FAIL fill_second_pc got %h exp 0104", bus.id_pc_next); end
        n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_back got %b exp 1", bus.if_ready); end
        @(negedge clk);
        n_vec++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL fill_no_third got %b exp 0", bus.id_valid); end
        $display("test_stall_fill: 1111,2222 accepted, 3333 refused");
    endtask

    task automatic test_back_to_back();
        logic [15:0] ei;
        logic [15:0] ep;
        int          kp;
        for (int k = 0; k <= 8; k++) begin
            kp = k - 1;
            ei = 16'h6000 | 16'(kp);
            ep = 16'h0100 + 16'(2 * kp);
            if (k > 0) begin
                n_vec++; if (bus.id_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got %b exp 1", kp, bus.id_valid); end
                n_vec++; if (bus.id_instr !== ei) begin n_err++; $display("FAIL b2b_instr[%0d] got %h exp %h", kp, bus.id_instr, ei); end
                n_vec++; if (bus.id_pc_next !== ep) begin n_err++; $display("FAIL b2b_pc[%0d] got %h exp %h", kp, bus.id_pc_next, ep); end
                n_vec++; if (bus.id_err !== kp[0]) begin n_err++; $display("FAIL b2b_err[%0d] got %b exp %b", kp, bus.id_err, kp[0]); end
                n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %b exp 1", kp, bus.if_ready); end
                $display("b2b: entry %0d instr %h pc %h err %b", kp, bus.id_instr, bus.id_pc_next, bus.id_err);
            end
            if (k < 8) drive(1'b1, 16'h0100 + 16'(2 * k), 16'h6000 | 16'(k), k[0], 1'b1, 1'b0);
            else       drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
        end
        n_vec++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained got %b exp 0", bus.id_valid); end
    endtask

    task automatic test_halt();
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_pre got %b exp 0", halted); end
        drive(1'b1, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_set got %b exp 1", halted); end
        n_vec++; if (bus.if_ready !== 1'b0) begin n_err++; $display("FAIL halt_ready got %b exp 0", bus.if_ready); end
        n_vec++; if (bus.id_instr !== 16'h0000) begin n_err++; $display("FAIL halt_head got %h exp 0000", bus.id_instr); end
        n_vec++; if (bus.id_pc_next !== 16'h0010) begin n_err++; $display("FAIL halt_head_pc got %h exp 0010", bus.id_pc_next); end
        drive(1'b1, 16'h0012, 16'h7777, 1'b0, 1'b1, 1'b0);
        exp_stall++;
        @(negedge clk);
        n_vec++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL halt_locked_push got %b exp 0", bus.id_valid); end
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_hold got %b exp 1", halted); end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_flush got %b exp 0", halted); end
        n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL halt_flush_ready got %b exp 1", bus.if_ready); end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        $display("test_halt: HALT drained, lock cleared by flush");
    endtask

    task automatic test_flush();
        drive(1'b1, 16'h0020, 16'hA1A1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h0022, 16'hB2B2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++; if (bus.if_ready !== 1'b0) begin n_err++; $display("FAIL flush_full_ready got %b exp 0", bus.if_ready); end
        n_vec++; if (bus.id_instr !== 16'hA1A1) begin n_err++; $display("FAIL flush_full_head got %h exp a1a1", bus.id_instr); end
        drive(1'b1, 16'h0024, 16'hC3C3, 1'b0, 1'b1, 1'b1);
        exp_stall++;
        @(negedge clk);
        n_vec++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL flush_full_valid got %b exp 0", bus.id_valid); end
        n_vec++; if (bus.id_instr !== 16'h0800) begin n_err++; $display("FAIL flush_full_instr got %h exp 0800", bus.id_instr); end
        n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL flush_full_ready_after got %b exp 1", bus.if_ready); end
        drive(1'b1, 16'h0030, 16'hD4D4, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++; if (bus.id_instr !== 16'hD4D4) begin n_err++; $display("FAIL flush_one_head got %h exp d4d4", bus.id_instr); end
        drive(1'b1, 16'h0032, 16'hE5E5, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        n_vec++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL flush_one_valid got %b exp 0", bus.id_valid); end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_vec++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL flush_push_leak got %b exp 0", bus.id_valid); end
        $display("test_flush: flush discarded queued and concurrent entries");
    endtask

    task automatic test_async_reset();
`ifdef FDQ_STALL_COUNT_EN
        n_vec++; if (stall_cnt !== 16'(exp_stall)) begin n_err++; $display("FAIL stall_cnt got %0d exp %0d", stall_cnt, exp_stall); end
`endif
        drive(1'b1, 16'h0040, 16'hF6F6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h0042, 16'h1717, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        n_vec++; if (bus.id_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre_valid got %b exp 1", bus.id_valid); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid got %b exp 0", bus.id_valid); end
        n_vec++; if (bus.id_instr !== 16'h0800) begin n_err++; $display("FAIL areset_instr got %h exp 0800", bus.id_instr); end
        n_vec++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL areset_ready got %b exp 1", bus.if_ready); end
`ifdef FDQ_STALL_COUNT_EN
        n_vec++; if (stall_cnt !== 16'h0000) begin n_err++; $display("FAIL areset_stall_cnt got %h exp 0000", stall_cnt); end
`endif
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 16'h0050, 16'h2828, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++; if (bus.id_instr !== 16'h2828) begin n_err++; $display("FAIL areset_repush got %h exp 2828", bus.id_instr); end
        n_vec++; if (bus.id_err !== 1'b1) begin n_err++; $display("FAIL areset_repush_err got %b exp 1", bus.id_err); end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        $display("test_async_reset: queue cleared between edges");
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        exp_stall = 0;
        rst       = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        test_reset();
        test_flow_through();
        test_stall_fill();
        test_back_to_back();
        test_halt();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Buffers fetched instructions between the fetch stage and the decode stage.
- Accepts {PC+2, instruction, fetch error} from fetch through a valid/ready handshake and presents them in order to decode.
- Absorbs decode stalls, supports a branch/jump flush, and stops accepting instructions after a HALT has been queued.

Parameters:
- DEPTH, 2, number of queue entries; must be a power of two, minimum 2.
- PTR_W, 1, pointer width; equals log2(DEPTH).
- NOP_INSTR, 16'h0800, instruction value driven on id_instr when the queue is empty or in reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  discard all queued entries and clear the halt lock.
- if_valid  input  1  fetch presents a valid entry.
- if_ready  output  1  queue accepts an entry this cycle.
- if_pc_next  input  16  PC+2 produced by fetch.
- if_instr  input  16  instruction word from instruction memory.
- if_err  input  1  fetch error (PC increment overflow/zero).
- id_valid  output  1  head entry is valid.
- id_ready  input  1  decode consumes the head entry this cycle.
- id_pc_next  output  16  PC+2 of the head entry.
- id_instr  output  16  instruction of the head entry.
- id_err  output  1  error flag of the head entry.
- halted  output  1  a HALT has been accepted; queue is locked.

Behaviour:
- State:
  - wr_ptr, rd_ptr: PTR_W bits each.
  - count: PTR_W+1 bits.
  - halt_lock: 1 bit.
  - Storage array of DEPTH x 33 bits {err, pc_next, instr}.
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, halt_lock=0.
  - Storage is not reset.
  - Reset outputs: id_valid=0, id_instr=NOP_INSTR, id_pc_next=16'h0000, id_err=0, halted=0, if_ready=1.
  - Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Handshake signals:
  - if_ready = (count != DEPTH) & ~halt_lock. It is combinational from state only and has no path from id_ready.
  - push = if_valid & if_ready & ~flush.
  - pop = id_valid & id_ready & ~flush.
- Outputs:
  - id_valid = (count != 0).
  - When count=0: id_instr=NOP_INSTR, id_pc_next=0, id_err=0.
  - Otherwise the outputs are a combinational read of storage[rd_ptr].
  - halted = halt_lock.
- Latency:
  - An entry pushed at edge N is visible on the id_* outputs after edge N.
  - There is no combinational bypass from if_* to id_*.
- Push:
  - Write storage[wr_ptr]; wr_ptr wraps modulo DEPTH.
  - If if_instr[15:11]==5'b00000 (HALT), set halt_lock at the same edge.
- Pop: rd_ptr increments, wrapping modulo DEPTH.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full (count==DEPTH): if_ready=0 even when a pop occurs in the same cycle.
- Empty with push: entry appears next cycle; no same-cycle forwarding.
- Flush:
  - Highest priority after reset.
  - At the edge: count=0, rd_ptr=wr_ptr=0, halt_lock=0.
  - Any push or pop in the same cycle is ignored.
  - The if_ready value during the flush cycle is irrelevant because push is masked.
- halt_lock:
  - Remains set until flush or reset.
  - Queued entries ahead of and including the HALT still drain to decode normally.
- Error flag:
  - id_err is carried per entry.
  - The queue never generates an error itself.

Optional Feature:
- Macro: FDQ_STALL_COUNT_EN.
- When defined:
  - Adds output stall_cnt [15:0]. It increments each cycle where if_valid=1 and if_ready=0, and saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package (processor constants file):
  - OPC_HALT = 5'b00000.
  - NOP_INSTR = 16'h0800.
  - Opcode field position [15:11].
  - Entry width constant 33.
- One natural sub-module: fdq_storage, the DEPTH x 33 register array with write port and asynchronous read port, no reset.
- Pointer, count and lock control stay in the top module.

Test Plan:
- Reset and flow-through:
  - Release rst, hold id_ready=1, push {pc_next=16'h0002, instr=16'h4123} -> next cycle id_valid=1, id_instr=16'h4123, id_pc_next=16'h0002.
  - The cycle after that, id_valid=0 and id_instr=16'h0800.
- Stall fill:
  - id_ready=0, push 3 entries 16'h1111, 16'h2222, 16'h3333 -> first two accepted; if_ready=0 on the third.
  - Release id_ready -> outputs 16'h1111 then 16'h2222 in order, and if_ready returns to 1.
- Simultaneous push/pop at count=1:
  - count stays 1; order is preserved across pointer wrap for 8 consecutive entries.
- HALT lock:
  - Push 16'h0000 -> halted=1 next cycle and if_ready=0.
  - The HALT entry still reaches decode.
  - Pulse flush -> halted=0 and if_ready=1.
- Flush with concurrent push/pop when full:
  - Next cycle id_valid=0 and count=0; the pushed entry is never presented.
- Asynchronous reset mid-operation:
  - Drop rst between edges with 2 entries queued -> id_valid=0 immediately.
  - With FDQ_STALL_COUNT_EN, stall_cnt=0.
